alu: RTL and testbench



---
 rtl/alu.sv | 113 +++++++++++
 tb/tb_alu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit integer ALU: add/subtract, bitwise logic, shifts and signed/unsigned
// compares, with the result and flags registered one clock after the operands.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        AddSel,
    input  logic        ArithSel,
    input  logic [2:0]  ALUSel,
    input  logic [2:0]  CompSel,
    input  logic        sign,
    output logic [31:0] z,
    output logic        overflow,
    output logic        zero,
    output logic        cflag
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SR  = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;

    logic [31:0] b_op;
    logic [32:0] sum;
    logic        add_ovf;
    logic [4:0]  shamt;
    logic [31:0] sll_res;
    logic [31:0] sr_res;
    logic        lt;
    logic        eq;
    logic        cmp_bit;
    logic [31:0] r;
    logic        r_ovf;
    logic        r_carry;

    // Subtract is a + ~b + 1, so the carry-in doubles as the subtract select.
    always_comb begin
        b_op = AddSel ? ~b : b;
        sum  = {1'b0, a} + {1'b0, b_op} + {32'b0, AddSel};
        if (AddSel)
            add_ovf = (a[31] != b[31]) && (sum[31] != a[31]);
        else
            add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    end

    always_comb begin
        shamt   = b[4:0];
        sll_res = a << shamt;
        if (ArithSel)
            sr_res = $unsigned($signed(a) >>> shamt);
        else
            sr_res = a >> shamt;
    end

    // All six relations derive from one less-than and one equality.
    always_comb begin
        eq = (a == b);
        if (sign)
            lt = ($signed(a) < $signed(b));
        else
            lt = (a < b);
        cmp_bit = 1'b0;
        casez (CompSel)
            3'b000:  cmp_bit = !lt && !eq;
            3'b001:  cmp_bit = !lt;
            3'b010:  cmp_bit = lt;
            3'b011:  cmp_bit = lt || eq;
            3'b1?0:  cmp_bit = eq;
            3'b1?1:  cmp_bit = !eq;
            default: cmp_bit = 1'b0;
        endcase
    end

    always_comb begin
        r       = 32'h0;
        r_ovf   = 1'b0;
        r_carry = 1'b0;
        case (ALUSel)
            OP_ADD: begin
                r       = sum[31:0];
                r_ovf   = sign && add_ovf;
                r_carry = !sign && sum[32];
            end
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = sll_res;
            OP_SR:   r = sr_res;
            OP_CMP:  r = {31'b0, cmp_bit};
            default: r = 32'h0;
        endcase
    end

    // zero is cleared in reset even though z is also 0 then.
    always_ff @(posedge clk) begin
        if (rst) begin
            z        <= 32'h0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            cflag    <= 1'b0;
        end else begin
            z        <= r;
            overflow <= r_ovf;
            zero     <= (r == 32'h0);
            cflag    <= r_carry;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases with literal expectations, then random
// operations scored against an arithmetic reference model.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        add_sel;
    logic        arith_sel;
    logic [2:0]  alu_sel;
    logic [2:0]  comp_sel;
    logic        sign;
    logic [31:0] z;
    logic        overflow;
    logic        zero;
    logic        cflag;

    int checks = 0;
    int errors = 0;

    logic [34:0] exp_q[$];

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .AddSel   (add_sel),
        .ArithSel (arith_sel),
        .ALUSel   (alu_sel),
        .CompSel  (comp_sel),
        .sign     (sign),
        .z        (z),
        .overflow (overflow),
        .zero     (zero),
        .cflag    (cflag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: result packed as {z, overflow, zero, cflag}.
    function automatic logic [34:0] model(input logic r_rst, input logic [31:0] ma,
                                          input logic [31:0] mb, input logic m_sub,
                                          input logic m_arith, input logic [2:0] m_op,
                                          input logic [2:0] m_cs, input logic m_sign);
        longint ua, ub, sa, sb, full, sres, va, vb;
        logic [31:0] res;
        logic ov, cy, c;
        int n;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        n = int'(mb[4:0]);
        res = 32'h0;
        ov = 1'b0;
        cy = 1'b0;
        if (r_rst) return 35'h0;
        case (m_op)
            3'd0: begin
                full = m_sub ? (ua - ub + 64'h1_0000_0000) : (ua + ub);
                res  = full[31:0];
                sres = m_sub ? (sa - sb) : (sa + sb);
                ov   = m_sign && (sres > 64'sd2147483647 || sres < -64'sd2147483648);
                cy   = !m_sign && (full >= 64'h1_0000_0000);
            end
            3'd1: res = ma | mb;
            3'd2: res = ma & mb;
            3'd3: res = ma ^ mb;
            3'd4: begin
                full = (ua * (64'd1 << n)) % 64'h1_0000_0000;
                res  = full[31:0];
            end
            3'd5: begin
                full = m_arith ? (sa >>> n) : (ua / (64'd1 << n));
                res  = full[31:0];
            end
            3'd6: begin
                va = m_sign ? sa : ua;
                vb = m_sign ? sb : ub;
                case (m_cs)
                    3'd0: c = va > vb;
                    3'd1: c = va >= vb;
                    3'd2: c = va < vb;
                    3'd3: c = va <= vb;
                    3'd4, 3'd6: c = va == vb;
                    default: c = va != vb;
                endcase
                res = {31'b0, c};
            end
            default: res = 32'h0;
        endcase
        return {res, ov, (res == 32'h0), cy};
    endfunction

    task automatic set_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] op,
                          input logic [2:0] cs, input logic sub, input logic ars, input logic sg);
        a = ta;
        b = tb;
        alu_sel = op;
        comp_sel = cs;
        add_sel = sub;
        arith_sel = ars;
        sign = sg;
    endtask

    // Inputs set just after an edge are sampled by the next one; check #1 later.
    task automatic dir(input string tag, input logic [31:0] ez, input logic eo,
                       input logic ezr, input logic ec);
        @(posedge clk);
        #1;
        check({tag, ".z"}, z, ez);
        check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, eo});
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, ezr});
        check({tag, ".cflag"}, {31'b0, cflag}, {31'b0, ec});
    endtask

    task automatic rand_step();
        logic [34:0] e;
        exp_q.push_back(model(rst, a, b, add_sel, arith_sel, alu_sel, comp_sel, sign));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("rnd.z", z, e[34:3]);
        check("rnd.ovf", {31'b0, overflow}, {31'b0, e[2]});
        check("rnd.zero", {31'b0, zero}, {31'b0, e[1]});
        check("rnd.cflag", {31'b0, cflag}, {31'b0, e[0]});
    endtask

    initial begin
        rst = 1'b1;
        set_op(32'hffffffff, 32'h1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        dir("post_reset", 32'h0, 1'b0, 1'b1, 1'b1);

        set_op(32'h80000000, 32'hffffffff, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("add_u", 32'h7fffffff, 1'b0, 1'b0, 1'b1);
        set_op(32'h80000000, 32'hffffffff, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        dir("add_s", 32'h7fffffff, 1'b1, 1'b0, 1'b0);
        set_op(32'h80000000, 32'h7fffffff, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        dir("sub_s", 32'h00000001, 1'b1, 1'b0, 1'b0);
        set_op(32'h0, 32'h1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        dir("sub_u", 32'hffffffff, 1'b0, 1'b0, 1'b0);
        set_op(32'h5, 32'h5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        dir("sub_eq", 32'h0, 1'b0, 1'b1, 1'b1);

        set_op(32'h11111111, 32'hffffffff, 3'd1, 3'd0, 1'b1, 1'b1, 1'b1);
        dir("or", 32'hffffffff, 1'b0, 1'b0, 1'b0);
        set_op(32'h11111111, 32'hffffffff, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("and", 32'h11111111, 1'b0, 1'b0, 1'b0);
        set_op(32'h11111111, 32'hffffffff, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("xor", 32'heeeeeeee, 1'b0, 1'b0, 1'b0);

        set_op(32'h000000ab, 32'h11, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("sll", 32'h01560000, 1'b0, 1'b0, 1'b0);
        set_op(32'h80000d2c, 32'h1000, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("sll0", 32'h80000d2c, 1'b0, 1'b0, 1'b0);
        set_op(32'hffff0000, 32'h5, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("srl", 32'h07fff800, 1'b0, 1'b0, 1'b0);
        set_op(32'h80000000, 32'h5, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0);
        dir("sra", 32'hfc000000, 1'b0, 1'b0, 1'b0);

        set_op(32'hffffffff, 32'h0000ffff, 3'd6, 3'd2, 1'b0, 1'b0, 1'b1);
        dir("lt_s", 32'h1, 1'b0, 1'b0, 1'b0);
        set_op(32'hffffffff, 32'h0000ffff, 3'd6, 3'd2, 1'b1, 1'b1, 1'b0);
        dir("lt_u", 32'h0, 1'b0, 1'b1, 1'b0);
        set_op(32'h1234, 32'h1234, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0);
        dir("eq110", 32'h1, 1'b0, 1'b0, 1'b0);
        set_op(32'h1234, 32'h1234, 3'd6, 3'd7, 1'b0, 1'b0, 1'b0);
        dir("ne111", 32'h0, 1'b0, 1'b1, 1'b0);
        set_op(32'hdeadbeef, 32'h1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("rsvd", 32'h0, 1'b0, 1'b1, 1'b0);

        // Back-to-back OR, SLL, compare with one result per edge.
        set_op(32'h0f000000, 32'h000000f0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("b2b_or", 32'h0f0000f0, 1'b0, 1'b0, 1'b0);
        set_op(32'h00000003, 32'h00000004, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("b2b_sll", 32'h00000030, 1'b0, 1'b0, 1'b0);
        set_op(32'h00000003, 32'h00000004, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0);
        dir("b2b_cmp", 32'h0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: rb = $urandom_range(0, 63);
                2: ra = {ra[31], 31'h0};
                default: ;
            endcase
            rst = ($urandom_range(0, 39) == 0);
            set_op(ra, rb, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            rand_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
